// File: rtl/cpu6_div_seq_pkg.sv
// Shared constants, funct3 encodings and state encodings for the cpu6 sequential divider.
package cpu6_div_seq_pkg;

  localparam int XLEN                 = 32;
  localparam int CNT_W                = 5;
  localparam int CPU6_DIV_STATE_SIZE  = 2;

  localparam logic [CNT_W-1:0] CNT_INIT = 5'd31;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONE = 32'hFFFF_FFFF;

  typedef enum logic [CPU6_DIV_STATE_SIZE-1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Two's-complement magnitude; INT_MIN maps onto itself, which is the correct unsigned value.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/cpu6_div_seq_if.sv
// Request/response handshake bundle between the pipeline and the cpu6 divider.
interface cpu6_div_seq_if;
  logic                                 req_valid;
  logic                                 req_ready;
  logic [2:0]                           funct3;
  logic [cpu6_div_seq_pkg::XLEN-1:0]    src_a;
  logic [cpu6_div_seq_pkg::XLEN-1:0]    src_b;
  logic                                 flush;
  logic                                 resp_valid;
  logic                                 resp_ready;
  logic [cpu6_div_seq_pkg::XLEN-1:0]    result;
  logic                                 busy;

  modport master (
    output req_valid, funct3, src_a, src_b, flush, resp_ready,
    input  req_ready, resp_valid, result, busy
  );

  modport slave (
    input  req_valid, funct3, src_a, src_b, flush, resp_ready,
    output req_ready, resp_valid, result, busy
  );
endinterface

// File: rtl/cpu6_div_step.sv
// One restoring radix-2 division step: shift in a dividend bit, subtract the divisor if it fits.
module cpu6_div_step
  import cpu6_div_seq_pkg::*;
(
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic            din,
  output logic [XLEN:0]   rem_out,
  output logic            q_bit
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] trial;

  assign shifted = {rem_in, din};
  assign trial   = shifted - {2'b00, divisor};
  assign q_bit   = ~trial[XLEN+1];
  assign rem_out = q_bit ? trial[XLEN:0] : shifted[XLEN:0];

endmodule

// File: rtl/cpu6_div_seq.sv
// Sequential 32-bit DIV/DIVU/REM/REMU unit, one quotient bit per cycle.
// Optional early completion of divide-by-zero / signed overflow: define CPU6_DIV_FASTPATH_EN.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// CALC  | 32 restoring steps, then one cycle for sign fix-up into result
// DONE  | result held with resp_valid until consumed or flushed
module cpu6_div_seq
  import cpu6_div_seq_pkg::*;
(
  input  logic           clk,
  input  logic           resetn,
  cpu6_div_seq_if.slave  bus
);

  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             fin;
  logic [XLEN:0]    rem;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  divisor;
  logic [XLEN-1:0]  a_raw;
  logic [XLEN-1:0]  result_q;
  logic             is_signed, is_rem, sign_a, sign_b, div_zero, ovf;

  logic [2:0]       f3_norm;
  logic             in_signed, in_rem, in_sign_a, in_sign_b;
  logic             accept, fast, unused_f3;
  logic [XLEN:0]    rem_nxt;
  logic             q_bit;
  logic [XLEN-1:0]  q_fix, r_fix, final_res;

  assign unused_f3 = bus.funct3[2];
  assign f3_norm   = {1'b1, bus.funct3[1:0]};
  assign in_signed = (f3_norm == F3_DIV) || (f3_norm == F3_REM);
  assign in_rem    = (f3_norm == F3_REM) || (f3_norm == F3_REMU);
  assign in_sign_a = in_signed & bus.src_a[XLEN-1];
  assign in_sign_b = in_signed & bus.src_b[XLEN-1];

  assign accept = (state == ST_IDLE) & bus.req_valid & ~bus.flush;

`ifdef CPU6_DIV_FASTPATH_EN
  assign fast = div_zero | ovf;
`else
  assign fast = 1'b0;
`endif

  cpu6_div_step u_step (
    .rem_in  (rem),
    .divisor (divisor),
    .din     (quo[XLEN-1]),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_CALC;
      ST_CALC: begin
        if (bus.flush)      state_nxt = ST_IDLE;
        else if (fin | fast) state_nxt = ST_DONE;
      end
      ST_DONE: if (bus.flush || bus.resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    q_fix = (is_signed & (sign_a ^ sign_b)) ? (~quo + 32'd1) : quo;
    r_fix = (is_signed & sign_a) ? (~rem[XLEN-1:0] + 32'd1) : rem[XLEN-1:0];
    // Special cases override the iterative result so the fast path needs no step data.
    if (div_zero) begin
      q_fix = ALL_ONE;
      r_fix = a_raw;
    end else if (ovf) begin
      q_fix = INT_MIN;
      r_fix = '0;
    end
    final_res = is_rem ? r_fix : q_fix;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      fin       <= 1'b0;
      rem       <= '0;
      quo       <= '0;
      divisor   <= '0;
      a_raw     <= '0;
      result_q  <= '0;
      is_signed <= 1'b0;
      is_rem    <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept) begin
      cnt       <= CNT_INIT;
      fin       <= 1'b0;
      rem       <= '0;
      quo       <= mag(bus.src_a, in_sign_a);
      divisor   <= mag(bus.src_b, in_sign_b);
      a_raw     <= bus.src_a;
      is_signed <= in_signed;
      is_rem    <= in_rem;
      sign_a    <= in_sign_a;
      sign_b    <= in_sign_b;
      div_zero  <= (bus.src_b == '0);
      ovf       <= in_signed && (bus.src_a == INT_MIN) && (bus.src_b == ALL_ONE);
    end else if (state == ST_CALC && !bus.flush) begin
      if (fin | fast) begin
        result_q <= final_res;
      end else begin
        rem <= rem_nxt;
        quo <= {quo[XLEN-2:0], q_bit};
        if (cnt == '0) fin <= 1'b1;
        else           cnt <= cnt - 5'd1;
      end
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = (state == ST_DONE);
  assign bus.busy       = (state == ST_CALC) || (state == ST_DONE);
  assign bus.result     = result_q;

endmodule

// File: tb/tb_cpu6_div_seq.sv
// Directed self-checking bench for cpu6_div_seq; expected latencies follow CPU6_DIV_FASTPATH_EN.
module tb_cpu6_div_seq;
  import cpu6_div_seq_pkg::*;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

`ifdef CPU6_DIV_FASTPATH_EN
  localparam int LAT_SPECIAL = 1;
`else
  localparam int LAT_SPECIAL = 33;
`endif
  localparam int LAT_NORMAL = 33;

  cpu6_div_seq_if bus ();

  cpu6_div_seq dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.funct3    = f3;
    bus.src_a     = a;
    bus.src_b     = b;
    check({tag, " ready"}, {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.resp_valid && lat < 40);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, bus.result, exp);
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check({tag, " idle"}, {30'd0, bus.req_ready, bus.resp_valid}, 32'd2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    bus.req_valid  = 1'b0;
    bus.funct3     = 3'b100;
    bus.src_a      = '0;
    bus.src_b      = '0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b0;

    #12;
    check("reset ready", {31'd0, bus.req_ready}, 32'd1);
    check("reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset result", bus.result, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    run_op("divu", F3_DIVU, 32'd100, 32'd7, 32'd14, LAT_NORMAL);
    run_op("remu", F3_REMU, 32'd100, 32'd7, 32'd2, LAT_NORMAL);
    run_op("div_neg", F3_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, LAT_NORMAL);
    run_op("rem_neg", F3_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, LAT_NORMAL);
    run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPECIAL);
    run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, LAT_SPECIAL);
    run_op("div_zero", F3_DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFFF, LAT_SPECIAL);
    run_op("remu_zero", F3_REMU, 32'd5, 32'h0, 32'd5, LAT_SPECIAL);
    run_op("rem_zero_neg", F3_REM, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, LAT_SPECIAL);
    run_op("divu_big", F3_DIVU, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, LAT_NORMAL);
    run_op("div_mixed", F3_DIV, 32'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72, LAT_NORMAL);
    run_op("rem_mixed", F3_REM, 32'd1000, 32'hFFFF_FFF9, 32'd6, LAT_NORMAL);
    run_op("f3_alias", 3'b001, 32'd100, 32'd7, 32'd14, LAT_NORMAL);

    // Response held off for 10 cycles.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.funct3 = F3_DIVU; bus.src_a = 32'd1000; bus.src_b = 32'd10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 33; i++) begin @(posedge clk); #1; end
    check("hold start valid", {31'd0, bus.resp_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold result", bus.result, 32'd100);
      check("hold flags", {30'd0, bus.req_ready, bus.resp_valid}, 32'd1);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("hold release", {29'd0, bus.req_ready, bus.resp_valid, bus.busy}, 32'd4);

    // Flush at CALC cycle 10 with a competing request.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.funct3 = F3_DIVU; bus.src_a = 32'd500; bus.src_b = 32'd3;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
    @(negedge clk);
    bus.flush = 1'b1; bus.req_valid = 1'b1; bus.src_a = 32'd77; bus.src_b = 32'd7;
    @(posedge clk); #1;
    check("flush state", {29'd0, bus.req_ready, bus.resp_valid, bus.busy}, 32'd4);
    @(negedge clk);
    bus.flush = 1'b0; bus.req_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check("flush quiet", {30'd0, bus.resp_valid, bus.busy}, 32'd0);
    end
    run_op("after_flush", F3_DIVU, 32'd77, 32'd7, 32'd11, LAT_NORMAL);

    // Flush together with resp_ready in DONE.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.funct3 = F3_REMU; bus.src_a = 32'd9; bus.src_b = 32'd4;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 33; i++) begin @(posedge clk); #1; end
    check("done rem", bus.result, 32'd1);
    @(negedge clk);
    bus.flush = 1'b1; bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.resp_ready = 1'b0;
    check("done flush", {29'd0, bus.req_ready, bus.resp_valid, bus.busy}, 32'd4);

    // Reset mid-CALC discards the operation.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.funct3 = F3_DIVU; bus.src_a = 32'd50; bus.src_b = 32'd5;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("async reset", {29'd0, bus.req_ready, bus.resp_valid, bus.busy}, 32'd4);
    check("async reset result", bus.result, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check("post reset quiet", {30'd0, bus.resp_valid, bus.busy}, 32'd0);
    end
    run_op("after_reset", F3_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF6, 32'd10, LAT_NORMAL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
